// File: rtl/status_reg_pkg.sv
// ============================================================================
// status_reg_pkg : shared flag indices, flag command codes, reset P value
// Revision 1.0
// ============================================================================
`default_nettype none

package status_reg_pkg;

  localparam int FLAG_N = 7;
  localparam int FLAG_V = 6;
  localparam int FLAG_U = 5;
  localparam int FLAG_B = 4;
  localparam int FLAG_D = 3;
  localparam int FLAG_I = 2;
  localparam int FLAG_Z = 1;
  localparam int FLAG_C = 0;

  localparam logic [7:0] RESET_P_DEFAULT = 8'h34;

  typedef enum logic [3:0] {
    FLG_NONE = 4'd0,
    FLG_CLC  = 4'd1,
    FLG_SEC  = 4'd2,
    FLG_CLI  = 4'd3,
    FLG_SEI  = 4'd4,
    FLG_CLV  = 4'd5,
    FLG_CLD  = 4'd6,
    FLG_SED  = 4'd7,
    FLG_PLP  = 4'd8,
    FLG_BIT  = 4'd9
  } flag_op_e;

endpackage

`default_nettype wire

// File: rtl/status_reg_int_sync.sv
// ============================================================================
// status_reg_int_sync : nmi_n/irq_n synchronizer and NMI falling-edge latch
// Revision 1.0
// ============================================================================
`default_nettype none

module status_reg_int_sync #(
  parameter int unsigned NMI_SYNC = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic nmi_n_i,
  input  logic irq_n_i,
  input  logic int_ack_i,
  output logic nmi_pending_o,
  output logic irq_s_o
);

  logic nmi_s;
  logic nmi_prev_q;
  logic nmi_latch_q, nmi_latch_d;

  if (NMI_SYNC != 0) begin : g_sync
    logic nmi_meta_q;
    logic irq_meta_q;
    always_ff @(posedge clk) begin
      if (rst) begin
        nmi_meta_q <= 1'b1;
        irq_meta_q <= 1'b1;
      end else begin
        nmi_meta_q <= nmi_n_i;
        irq_meta_q <= irq_n_i;
      end
    end
    assign nmi_s   = nmi_meta_q;
    assign irq_s_o = irq_meta_q;
  end else begin : g_direct
    assign nmi_s   = nmi_n_i;
    assign irq_s_o = irq_n_i;
  end

  // A fresh edge wins over a simultaneous acknowledge so no NMI is lost.
  always_comb begin
    nmi_latch_d = nmi_latch_q;
    if (int_ack_i && nmi_latch_q) nmi_latch_d = 1'b0;
    if (nmi_prev_q && !nmi_s)     nmi_latch_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      nmi_prev_q  <= 1'b1;
      nmi_latch_q <= 1'b0;
    end else begin
      nmi_prev_q  <= nmi_s;
      nmi_latch_q <= nmi_latch_d;
    end
  end

  assign nmi_pending_o = nmi_latch_q;

endmodule

`default_nettype wire

// File: rtl/status_reg.sv
// ============================================================================
// status_reg : 6502 P register with flag update muxing and IRQ/NMI qualification
// Revision 1.0
// ============================================================================
`default_nettype none

module status_reg
  import status_reg_pkg::*;
#(
  parameter logic [7:0]  RESET_P  = RESET_P_DEFAULT,
  parameter int unsigned NMI_SYNC = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] alu_out,
  input  logic       alu_c,
  input  logic       alu_v,
  input  logic       upd_nz,
  input  logic       upd_c,
  input  logic       upd_v,
  input  logic [3:0] flag_op,
  input  logic [7:0] data_in,
  input  logic       sync,
  input  logic       push_brk,
  input  logic       int_ack,
  input  logic       nmi_n,
  input  logic       irq_n,
  output logic [7:0] p,
  output logic [7:0] p_push,
  output logic       nmi_pending,
  output logic       irq_pending
);

  logic n_q, v_q, d_q, i_q, z_q, c_q;
  logic n_d, v_d, d_d, i_d, z_d, c_d;
  logic i_sync_q, i_sync_d;
  logic irq_pending_q;
  logic irq_s;
  logic alu_zero;
  logic unused_bits;

  assign alu_zero    = (alu_out == 8'h00);
  assign unused_bits = ^data_in[FLAG_U:FLAG_B];

  // Assignments run lowest priority first so later ones override.
  always_comb begin
    n_d = n_q;
    v_d = v_q;
    d_d = d_q;
    i_d = i_q;
    z_d = z_q;
    c_d = c_q;
    if (upd_nz) begin
      n_d = alu_out[7];
      z_d = alu_zero;
    end
    if (upd_c)   c_d = alu_c;
    if (upd_v)   v_d = alu_v;
    if (int_ack) i_d = 1'b1;
    case (flag_op)
      FLG_CLC: c_d = 1'b0;
      FLG_SEC: c_d = 1'b1;
      FLG_CLI: i_d = 1'b0;
      FLG_SEI: i_d = 1'b1;
      FLG_CLV: v_d = 1'b0;
      FLG_CLD: d_d = 1'b0;
      FLG_SED: d_d = 1'b1;
      FLG_PLP: begin
        n_d = data_in[FLAG_N];
        v_d = data_in[FLAG_V];
        d_d = data_in[FLAG_D];
        i_d = data_in[FLAG_I];
        z_d = data_in[FLAG_Z];
        c_d = data_in[FLAG_C];
      end
      FLG_BIT: begin
        n_d = data_in[FLAG_N];
        v_d = data_in[FLAG_V];
        z_d = alu_zero;
      end
      default: ;
    endcase
  end

  // The IRQ mask copy follows I only at instruction boundaries.
  assign i_sync_d = sync ? i_q : i_sync_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      n_q           <= RESET_P[FLAG_N];
      v_q           <= RESET_P[FLAG_V];
      d_q           <= RESET_P[FLAG_D];
      i_q           <= RESET_P[FLAG_I];
      z_q           <= RESET_P[FLAG_Z];
      c_q           <= RESET_P[FLAG_C];
      i_sync_q      <= 1'b1;
      irq_pending_q <= 1'b0;
    end else begin
      n_q           <= n_d;
      v_q           <= v_d;
      d_q           <= d_d;
      i_q           <= i_d;
      z_q           <= z_d;
      c_q           <= c_d;
      i_sync_q      <= i_sync_d;
      irq_pending_q <= !irq_s && !i_sync_q;
    end
  end

  status_reg_int_sync #(
    .NMI_SYNC(NMI_SYNC)
  ) u_int_sync (
    .clk          (clk),
    .rst          (rst),
    .nmi_n_i      (nmi_n),
    .irq_n_i      (irq_n),
    .int_ack_i    (int_ack),
    .nmi_pending_o(nmi_pending),
    .irq_s_o      (irq_s)
  );

  assign p           = {n_q, v_q, 1'b1, 1'b1,     d_q, i_q, z_q, c_q};
  assign p_push      = {n_q, v_q, 1'b1, push_brk, d_q, i_q, z_q, c_q};
  assign irq_pending = irq_pending_q;

endmodule

`default_nettype wire

// File: tb/tb_status_reg.sv
// ============================================================================
// tb_status_reg : directed self-checking bench for status_reg
// Revision 1.0
// ============================================================================
`default_nettype none

module tb_status_reg;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] alu_out;
  logic       alu_c, alu_v, upd_nz, upd_c, upd_v;
  logic [3:0] flag_op;
  logic [7:0] data_in;
  logic       sync, push_brk, int_ack, nmi_n, irq_n;
  logic [7:0] p, p_push;
  logic       nmi_pending, irq_pending;

  int n_checks = 0;
  int n_fail   = 0;
  int rises;
  logic prev_pend;

  status_reg dut (
    .clk(clk), .rst(rst), .alu_out(alu_out), .alu_c(alu_c), .alu_v(alu_v),
    .upd_nz(upd_nz), .upd_c(upd_c), .upd_v(upd_v), .flag_op(flag_op),
    .data_in(data_in), .sync(sync), .push_brk(push_brk), .int_ack(int_ack),
    .nmi_n(nmi_n), .irq_n(irq_n), .p(p), .p_push(p_push),
    .nmi_pending(nmi_pending), .irq_pending(irq_pending)
  );

  always #5 clk = ~clk;

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    rst = 1'b1; alu_out = 8'h00; alu_c = 1'b0; alu_v = 1'b0;
    upd_nz = 1'b0; upd_c = 1'b0; upd_v = 1'b0; flag_op = 4'd0;
    data_in = 8'h00; sync = 1'b0; push_brk = 1'b0; int_ack = 1'b0;
    nmi_n = 1'b1; irq_n = 1'b0;
    tick(3);
    chk("reset_p", p, 8'h34);
    chk("reset_push", p_push, 8'h24);
    chk("reset_nmi", {7'd0, nmi_pending}, 8'h00);
    chk("reset_irq", {7'd0, irq_pending}, 8'h00);
    rst = 1'b0;
    tick(2);
    chk("irq_masked_after_reset", {7'd0, irq_pending}, 8'h00);

    // ALU result N/V/C update
    alu_out = 8'h80; alu_c = 1'b1; alu_v = 1'b1;
    upd_nz = 1'b1; upd_c = 1'b1; upd_v = 1'b1;
    tick();
    upd_nz = 1'b0; upd_c = 1'b0; upd_v = 1'b0;
    chk("alu_update", p, 8'hF5);

    // PLP ignores bits 5:4
    flag_op = 4'd8; data_in = 8'hFF; tick();
    chk("plp_ff", p, 8'hFF);
    data_in = 8'h00; tick();
    chk("plp_00", p, 8'h30);

    // Mask IRQ at a boundary, then CLI mid-instruction
    flag_op = 4'd4; tick();
    flag_op = 4'd0; sync = 1'b1; tick();
    sync = 1'b0; tick(2);
    chk("irq_masked_sei", {7'd0, irq_pending}, 8'h00);
    flag_op = 4'd3; tick();
    flag_op = 4'd0;
    chk("cli_p", p, 8'h30);
    tick(2);
    chk("irq_delay_no_sync", {7'd0, irq_pending}, 8'h00);
    sync = 1'b1; tick();
    sync = 1'b0;
    chk("irq_at_sync_edge", {7'd0, irq_pending}, 8'h00);
    tick();
    chk("irq_after_sync", {7'd0, irq_pending}, 8'h01);
    flag_op = 4'd4; tick();
    flag_op = 4'd0; tick();
    chk("irq_held_after_sei", {7'd0, irq_pending}, 8'h01);
    sync = 1'b1; tick();
    sync = 1'b0; tick();
    chk("irq_dropped_sei_sync", {7'd0, irq_pending}, 8'h00);

    // NMI: held low level latches exactly once
    flag_op = 4'd3; tick();
    flag_op = 4'd0;
    chk("cli_before_nmi", p, 8'h30);
    nmi_n = 1'b0; rises = 0; prev_pend = nmi_pending;
    for (int k = 0; k < 10; k++) begin
      tick();
      if (nmi_pending && !prev_pend) rises++;
      prev_pend = nmi_pending;
    end
    chk("nmi_rise_count", rises[7:0], 8'd1);
    chk("nmi_latched", {7'd0, nmi_pending}, 8'h01);
    int_ack = 1'b1; tick();
    int_ack = 1'b0;
    chk("nmi_ack_clear", {7'd0, nmi_pending}, 8'h00);
    chk("ack_sets_i", p, 8'h34);
    tick(3);
    chk("nmi_level_no_retrigger", {7'd0, nmi_pending}, 8'h00);

    // New edge coinciding with acknowledge keeps the latch set
    nmi_n = 1'b1; tick(3);
    nmi_n = 1'b0; tick(3);
    chk("nmi_second", {7'd0, nmi_pending}, 8'h01);
    nmi_n = 1'b1; tick(3);
    chk("nmi_rise_keeps", {7'd0, nmi_pending}, 8'h01);
    nmi_n = 1'b0; tick();
    int_ack = 1'b1; tick();
    int_ack = 1'b0;
    chk("nmi_edge_with_ack", {7'd0, nmi_pending}, 8'h01);
    int_ack = 1'b1; tick();
    int_ack = 1'b0;
    chk("nmi_ack_after", {7'd0, nmi_pending}, 8'h00);

    // Flag op beats ALU update
    flag_op = 4'd2; upd_c = 1'b1; alu_c = 1'b0; tick();
    chk("sec_over_upd", p, 8'h35);
    flag_op = 4'd1; alu_c = 1'b1; tick();
    upd_c = 1'b0;
    chk("clc_over_upd", p, 8'h34);
    flag_op = 4'd2; tick();

    // BIT
    flag_op = 4'd9; data_in = 8'h40; alu_out = 8'h00; tick();
    chk("bit_op", p, 8'h77);

    // PLP beats int_ack for I
    flag_op = 4'd8; data_in = 8'h00; int_ack = 1'b1; tick();
    int_ack = 1'b0; flag_op = 4'd0;
    chk("plp_over_ack", p, 8'h30);
    push_brk = 1'b1; #1;
    chk("push_brk1", p_push, 8'h30);
    push_brk = 1'b0; #1;
    chk("push_brk0", p_push, 8'h20);

    // Reserved code is a no-op
    flag_op = 4'd12; data_in = 8'hFF; tick();
    chk("reserved_op", p, 8'h30);

    // Reset overrides a concurrent flag command
    flag_op = 4'd2; rst = 1'b1; tick();
    rst = 1'b0; flag_op = 4'd0;
    chk("reset_mid_p", p, 8'h34);
    chk("reset_mid_irq", {7'd0, irq_pending}, 8'h00);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
